// File: rtl/seq_detector_mealy.sv
// rtl/seq_detector_mealy.sv - parametrised Mealy serial sequence detector with run-time overlap select
// Optional saturating match counter (cnt_clr/match_cnt/cnt_sat) compiled in with SEQDET_MATCH_CNT_EN.
module seq_detector_mealy #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             d_valid,
  input  logic             d_in,
  input  logic             overlap,
`ifdef SEQDET_MATCH_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
`endif
  output logic             d_out
);

  localparam int             FW       = $clog2(PAT_LEN);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN - 1);

  if (PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1) begin : g_param_check
    $error("seq_detector_mealy: illegal parameter value");
  end

  logic [PAT_LEN-2:0] hist, hist_nxt;
  logic [FW-1:0]      fill, fill_nxt;
  logic [PAT_LEN-1:0] window;
  logic               match;

  always_ff @(posedge clk) begin
    if (n_reset) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= hist_nxt;
      fill <= fill_nxt;
    end
  end

  // fill gates the compare so reset zeros in hist can never fake a match
  always_comb begin
    window   = {hist, d_in};
    match    = d_valid && (fill == FILL_MAX) && (window == PATTERN);
    d_out    = !n_reset && match;
    hist_nxt = hist;
    fill_nxt = fill;
    if (d_valid) begin
      hist_nxt = window[PAT_LEN-2:0];
      if (match && !overlap) begin
        fill_nxt = '0;
      end else if (fill != FILL_MAX) begin
        fill_nxt = fill + 1'b1;
      end
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  assign cnt_sat = &match_cnt;

  always_ff @(posedge clk) begin
    if (n_reset || cnt_clr) begin
      match_cnt <= '0;
    end else if (d_out && !cnt_sat) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_mealy.sv
// tb/tb_seq_detector_mealy.sv - randomized and directed checks of seq_detector_mealy against a bit-history model
// Counter checks are active when SEQDET_MATCH_CNT_EN is defined.
module tb_seq_detector_mealy;

  localparam logic [3:0] PAT_A = 4'b1101;
  localparam logic [3:0] PAT_B = 4'b0001;

  logic clk     = 1'b0;
  logic n_reset = 1'b1;
  logic d_valid = 1'b0;
  logic d_in    = 1'b0;
  logic overlap = 1'b1;
  logic d_out_a, d_out_b;
`ifdef SEQDET_MATCH_CNT_EN
  logic       cnt_clr = 1'b0;
  logic [1:0] match_cnt_a, match_cnt_b;
  logic       cnt_sat_a, cnt_sat_b;
  int         cnt_model = 0;
  logic [1:0] cnt_act;
  logic       sat_act;
`endif

  int vectors     = 0;
  int miscompares = 0;
  bit q_a[$];
  bit q_b[$];
  bit exp_a, exp_b, act_a, act_b;

  always #5 clk = ~clk;

  seq_detector_mealy #(.PAT_LEN(4), .PATTERN(PAT_A), .CNT_W(2)) u_dut_a (
    .clk(clk), .n_reset(n_reset), .d_valid(d_valid), .d_in(d_in), .overlap(overlap),
`ifdef SEQDET_MATCH_CNT_EN
    .cnt_clr(cnt_clr), .match_cnt(match_cnt_a), .cnt_sat(cnt_sat_a),
`endif
    .d_out(d_out_a)
  );

  seq_detector_mealy #(.PAT_LEN(4), .PATTERN(PAT_B), .CNT_W(2)) u_dut_b (
    .clk(clk), .n_reset(n_reset), .d_valid(d_valid), .d_in(d_in), .overlap(overlap),
`ifdef SEQDET_MATCH_CNT_EN
    .cnt_clr(cnt_clr), .match_cnt(match_cnt_b), .cnt_sat(cnt_sat_b),
`endif
    .d_out(d_out_b)
  );

  // Model: the valid bits received since reset (or since the last non-overlapping match);
  // a match is the last four of them spelling the pattern.
  function automatic bit tail_match(input bit q[$], input logic [3:0] pat);
    if (q.size() < 4) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (q[q.size() - 4 + i] != pat[3 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive(input bit rst, input bit v, input bit d, input bit ov, input bit clr);
    n_reset = rst;
    d_valid = v;
    d_in    = d;
    overlap = ov;
`ifdef SEQDET_MATCH_CNT_EN
    cnt_clr = clr;
`endif
    exp_a = 1'b0;
    exp_b = 1'b0;
    if (!rst && v) begin
      q_a.push_back(d);
      q_b.push_back(d);
      if (q_a.size() > 4) void'(q_a.pop_front());
      if (q_b.size() > 4) void'(q_b.pop_front());
      exp_a = tail_match(q_a, PAT_A);
      exp_b = tail_match(q_b, PAT_B);
    end
    #2;
    act_a = d_out_a;
    act_b = d_out_b;
    if (rst) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (exp_a && !ov) q_a.delete();
      if (exp_b && !ov) q_b.delete();
    end
`ifdef SEQDET_MATCH_CNT_EN
    if (rst || clr) cnt_model = 0;
    else if (exp_a && cnt_model < 3) cnt_model++;
`else
    if (clr) exp_a = exp_a;
`endif
    @(posedge clk);
    #1;
`ifdef SEQDET_MATCH_CNT_EN
    cnt_act = match_cnt_a;
    sat_act = cnt_sat_a;
`endif
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 0);
    vectors++;
    if (act_a !== 1'b0) begin miscompares++; $display("FAIL reset_dout_a: d_out=%0b expected 0", act_a); end
    vectors++;
    if (act_b !== 1'b0) begin miscompares++; $display("FAIL reset_dout_b: d_out=%0b expected 0", act_b); end
`ifdef SEQDET_MATCH_CNT_EN
    vectors++;
    if (cnt_act !== 2'd0) begin miscompares++; $display("FAIL reset_cnt: match_cnt=%0d expected 0", cnt_act); end
`endif
  endtask

  task automatic test_basic();
    bit bits[5] = '{1, 1, 0, 1, 1};
    bit want[5] = '{0, 0, 0, 1, 0};
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, bits[i], 1, 0);
      vectors++;
      if (act_a !== want[i]) begin
        miscompares++; $display("FAIL basic bit%0d: d_out=%0b expected %0b", i + 1, act_a, want[i]);
      end
    end
  endtask

  task automatic test_overlap();
    bit bits[7]   = '{1, 1, 0, 1, 1, 0, 1};
    bit want_o[7] = '{0, 0, 0, 1, 0, 0, 1};
    bit want_n[7] = '{0, 0, 0, 1, 0, 0, 0};
    for (int m = 0; m < 2; m++) begin
      drive(1, 0, 0, 1, 0);
      for (int i = 0; i < 7; i++) begin
        drive(0, 1, bits[i], m[0], 0);
        vectors++;
        if (act_a !== (m[0] ? want_o[i] : want_n[i])) begin
          miscompares++;
          $display("FAIL overlap%0d bit%0d: d_out=%0b expected %0b", m, i + 1, act_a,
                   m[0] ? want_o[i] : want_n[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    drive(1, 0, 0, 1, 0);
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, ~i[0], 1, 0);
      vectors++;
      if (act_a !== 1'b0) begin miscompares++; $display("FAIL stall cyc%0d: d_out=%0b expected 0", i, act_a); end
    end
    drive(0, 1, 1, 1, 0);
    vectors++;
    if (act_a !== 1'b1) begin miscompares++; $display("FAIL stall_final: d_out=%0b expected 1", act_a); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 1, 0);
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 0, 1, 0);
    drive(1, 1, 1, 1, 0);
    vectors++;
    if (act_a !== 1'b0) begin miscompares++; $display("FAIL reset_mid_during: d_out=%0b expected 0", act_a); end
    drive(0, 1, 1, 1, 0);
    vectors++;
    if (act_a !== 1'b0) begin miscompares++; $display("FAIL reset_mid_after: d_out=%0b expected 0", act_a); end
  endtask

  task automatic test_startup();
    bit bits[5] = '{1, 0, 0, 0, 1};
    bit want[5] = '{0, 0, 0, 0, 1};
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, bits[i], 1, 0);
      vectors++;
      if (act_b !== want[i]) begin
        miscompares++; $display("FAIL startup bit%0d: d_out=%0b expected %0b", i + 1, act_b, want[i]);
      end
    end
  endtask

`ifdef SEQDET_MATCH_CNT_EN
  task automatic test_counter();
    bit         bits[16] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    logic [1:0] want[16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 0};
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, bits[i], 1, (i == 15));
      vectors++;
      if (cnt_act !== want[i] || sat_act !== (want[i] == 2'd3)) begin
        miscompares++;
        $display("FAIL counter bit%0d: match_cnt=%0d sat=%0b expected %0d sat=%0b", i + 1, cnt_act, sat_act,
                 want[i], want[i] == 2'd3);
      end
    end
    vectors++;
    if (act_a !== 1'b1) begin miscompares++; $display("FAIL counter_clr_match: d_out=%0b expected 1", act_a); end
  endtask
`endif

  task automatic test_random();
    bit rst, v, d, ov, clr;
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      v   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom);
      ov  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      drive(rst, v, d, ov, clr);
      vectors++;
      if (act_a !== exp_a || act_b !== exp_b) begin
        miscompares++;
        $display("FAIL random cyc%0d: d_out_a=%0b d_out_b=%0b expected %0b %0b", i, act_a, act_b, exp_a, exp_b);
      end
`ifdef SEQDET_MATCH_CNT_EN
      vectors++;
      if (cnt_act !== 2'(cnt_model) || sat_act !== (cnt_model == 3)) begin
        miscompares++;
        $display("FAIL random_cnt cyc%0d: match_cnt=%0d sat=%0b expected %0d sat=%0b", i, cnt_act, sat_act,
                 cnt_model, cnt_model == 3);
      end
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overlap();
    test_stall();
    test_reset_mid();
    test_startup();
`ifdef SEQDET_MATCH_CNT_EN
    test_counter();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
